// File: rtl/instruction_fetcher.sv
// instruction_fetcher: front-end fetch stage feeding the dispatcher.
// Holds the PC, issues one 32-bit fetch at a time to the memory controller,
// predicts the next PC for JAL/branches, and emits each word to the
// dispatcher as a one-cycle pulse. Stalls on RoB/RS/LSB full and redirects
// on RoB rollback.
// Optional build macro: FETCHER_BHT_EN enables a 2-bit saturating-counter BHT
// for branch prediction; without it, branches are predicted not taken.
//
// Handshake semantics:
//   Memory side: en_signal_to_mem is a level request with pc_to_mem held
//   stable until the single-cycle ok_flag_from_mem pulse that carries
//   inst_from_mem. The request drops in the cycle after that pulse.
//   Dispatcher side: ok_flag_to_dispatcher is a one-cycle valid pulse with
//   no back-pressure; the full flags stop the next request from being issued.
//   rdy_in=0 freezes every register and forces the dispatcher pulse low.
module instruction_fetcher #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          BHT_IDX_W = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        en_signal_to_mem,
  output logic [31:0] pc_to_mem,
  input  logic        ok_flag_from_mem,
  input  logic [31:0] inst_from_mem,
  input  logic        rob_full,
  input  logic        rs_full,
  input  logic        lsb_full,
  input  logic        rollback_flag_from_rob,
  input  logic [31:0] rollback_pc_from_rob,
  input  logic        bht_update_en,
  input  logic [31:0] bht_update_pc,
  input  logic        bht_update_taken,
  output logic        ok_flag_to_dispatcher,
  output logic [31:0] pc_to_dispatcher,
  output logic [31:0] inst_to_dispatcher,
  output logic        predicted_jump_to_dispatcher,
  output logic [31:0] rollback_pc_to_dispatcher
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state;
  logic [31:0] pc;

  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus_j;
  logic [31:0] pc_plus_b;
  logic        predict_taken;
  logic        any_full;

  logic [31:0] next_pc;
  logic [31:0] alt_pc;
  logic        next_pred;

  assign j_imm = {{12{inst_from_mem[31]}}, inst_from_mem[19:12], inst_from_mem[20],
                  inst_from_mem[30:21], 1'b0};
  assign b_imm = {{20{inst_from_mem[31]}}, inst_from_mem[7], inst_from_mem[30:25],
                  inst_from_mem[11:8], 1'b0};

  assign pc_plus4  = pc + 32'd4;
  assign pc_plus_j = pc + j_imm;
  assign pc_plus_b = pc + b_imm;
  assign any_full  = rob_full | rs_full | lsb_full;

`ifdef FETCHER_BHT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  // Counters packed two bits per entry; entry k lives at bits [2k+1:2k].
  logic [2*BHT_N-1:0]   bht;
  logic [BHT_IDX_W-1:0] lookup_idx;
  logic [BHT_IDX_W-1:0] update_idx;
  logic [1:0]           upd_cnt;
  logic [1:0]           lookup_cnt;

  assign lookup_idx    = pc[BHT_IDX_W+1:2];
  assign update_idx    = bht_update_pc[BHT_IDX_W+1:2];
  assign upd_cnt       = bht[{update_idx, 1'b0} +: 2];
  assign lookup_cnt    = bht[{lookup_idx, 1'b0} +: 2];
  assign predict_taken = lookup_cnt[1];

  // Saturating counter update on branch commit; a same-cycle lookup reads the old value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bht <= {BHT_N{2'b01}};
    end else if (rdy_in && bht_update_en) begin
      if (bht_update_taken) begin
        if (upd_cnt != 2'b11) bht[{update_idx, 1'b0} +: 2] <= upd_cnt + 2'd1;
      end else begin
        if (upd_cnt != 2'b00) bht[{update_idx, 1'b0} +: 2] <= upd_cnt - 2'd1;
      end
    end
  end

  logic unused_bht;
  assign unused_bht = ^{bht_update_pc[31:BHT_IDX_W+2], bht_update_pc[1:0]};
`else
  assign predict_taken = 1'b0;

  logic unused_bht;
  assign unused_bht = ^{bht_update_en, bht_update_pc, bht_update_taken};
`endif

  // Next-PC selection and the not-predicted path for the returned word.
  always_comb begin
    next_pc   = pc_plus4;
    alt_pc    = pc_plus4;
    next_pred = 1'b0;
    case (inst_from_mem[6:0])
      OP_JAL: begin
        next_pc   = pc_plus_j;
        next_pred = 1'b1;
      end
      OP_BRANCH: begin
        if (predict_taken) begin
          next_pc   = pc_plus_b;
          next_pred = 1'b1;
        end else begin
          alt_pc = pc_plus_b;
        end
      end
      default: begin
      end
    endcase
  end

  // Fetch FSM: request issue, response capture, rollback redirect and drain.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                        <= IDLE;
      pc                           <= RESET_PC;
      en_signal_to_mem             <= 1'b0;
      pc_to_mem                    <= 32'h0;
      ok_flag_to_dispatcher        <= 1'b0;
      pc_to_dispatcher             <= 32'h0;
      inst_to_dispatcher           <= 32'h0;
      predicted_jump_to_dispatcher <= 1'b0;
      rollback_pc_to_dispatcher    <= 32'h0;
    end else if (!rdy_in) begin
      ok_flag_to_dispatcher <= 1'b0;
    end else begin
      ok_flag_to_dispatcher <= 1'b0;
      if (rollback_flag_from_rob) begin
        pc <= rollback_pc_from_rob;
        case (state)
          BUSY, DRAIN: begin
            // A response landing in this same cycle ends the outstanding request.
            if (ok_flag_from_mem) begin
              en_signal_to_mem <= 1'b0;
              state            <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (!any_full) begin
              pc_to_mem        <= pc;
              en_signal_to_mem <= 1'b1;
              state            <= BUSY;
            end
          end
          BUSY: begin
            if (ok_flag_from_mem) begin
              en_signal_to_mem             <= 1'b0;
              ok_flag_to_dispatcher        <= 1'b1;
              pc_to_dispatcher             <= pc;
              inst_to_dispatcher           <= inst_from_mem;
              predicted_jump_to_dispatcher <= next_pred;
              rollback_pc_to_dispatcher    <= alt_pc;
              pc                           <= next_pc;
              state                        <= IDLE;
            end
          end
          DRAIN: begin
            if (ok_flag_from_mem) begin
              en_signal_to_mem <= 1'b0;
              state            <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed and randomized bench for instruction_fetcher.
// The reference model tracks the architectural PC and, when FETCHER_BHT_EN is
// defined, an array of integer counters. Instructions are generated from
// (kind, immediate) pairs so the model never decodes instruction bits.
`timescale 1ns/1ps
module tb_instruction_fetcher;

  localparam int          IDX_W  = 6;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCHER_BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif

  localparam int K_ADDI = 0;
  localparam int K_JAL  = 1;
  localparam int K_BR   = 2;
  localparam int K_JALR = 3;
  localparam int K_LUI  = 4;

  // clock / reset / DUT signals
  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        en_signal_to_mem;
  logic [31:0] pc_to_mem;
  logic        ok_flag_from_mem;
  logic [31:0] inst_from_mem;
  logic        rob_full;
  logic        rs_full;
  logic        lsb_full;
  logic        rollback_flag_from_rob;
  logic [31:0] rollback_pc_from_rob;
  logic        bht_update_en;
  logic [31:0] bht_update_pc;
  logic        bht_update_taken;
  logic        ok_flag_to_dispatcher;
  logic [31:0] pc_to_dispatcher;
  logic [31:0] inst_to_dispatcher;
  logic        predicted_jump_to_dispatcher;
  logic [31:0] rollback_pc_to_dispatcher;

  always #5 clk_in = ~clk_in;

  instruction_fetcher #(.RESET_PC(RST_PC), .BHT_IDX_W(IDX_W)) dut (
    .clk_in                       (clk_in),
    .rst_in                       (rst_in),
    .rdy_in                       (rdy_in),
    .en_signal_to_mem             (en_signal_to_mem),
    .pc_to_mem                    (pc_to_mem),
    .ok_flag_from_mem             (ok_flag_from_mem),
    .inst_from_mem                (inst_from_mem),
    .rob_full                     (rob_full),
    .rs_full                      (rs_full),
    .lsb_full                     (lsb_full),
    .rollback_flag_from_rob       (rollback_flag_from_rob),
    .rollback_pc_from_rob         (rollback_pc_from_rob),
    .bht_update_en                (bht_update_en),
    .bht_update_pc                (bht_update_pc),
    .bht_update_taken             (bht_update_taken),
    .ok_flag_to_dispatcher        (ok_flag_to_dispatcher),
    .pc_to_dispatcher             (pc_to_dispatcher),
    .inst_to_dispatcher           (inst_to_dispatcher),
    .predicted_jump_to_dispatcher (predicted_jump_to_dispatcher),
    .rollback_pc_to_dispatcher    (rollback_pc_to_dispatcher)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_pc;
  int          m_cnt [1<<IDX_W];
  logic [31:0] exp_q [$];   // expected dispatcher PCs, in order

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % (1 << IDX_W));
  endfunction

  function automatic bit m_predict(input logic [31:0] pc);
    return BHT_ON && (m_cnt[m_idx(pc)] >= 2);
  endfunction

  task automatic m_update(input logic [31:0] pc, input bit taken);
    if (BHT_ON) begin
      if (taken && m_cnt[m_idx(pc)] < 3) m_cnt[m_idx(pc)]++;
      else if (!taken && m_cnt[m_idx(pc)] > 0) m_cnt[m_idx(pc)]--;
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < (1 << IDX_W); i++) m_cnt[i] = 1;
    m_pc = RST_PC;
  endtask

  // RISC-V encoders: build a word of the given kind carrying imm.
  function automatic logic [31:0] enc(input int kind, input int imm);
    logic [31:0] iv;
    logic [4:0]  rd, r1, r2;
    iv = 32'(imm);
    rd = 5'($urandom_range(0, 31));
    r1 = 5'($urandom_range(0, 31));
    r2 = 5'($urandom_range(0, 31));
    case (kind)
      K_JAL:   enc = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'b1101111};
      K_BR:    enc = {iv[12], iv[10:5], r2, r1, 3'b000, iv[4:1], iv[11], 7'b1100011};
      K_JALR:  enc = {iv[11:0], r1, 3'b000, rd, 7'b1100111};
      K_LUI:   enc = {iv[31:12], rd, 7'b0110111};
      default: enc = {iv[11:0], r1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  task automatic model_fetch(input int kind, input int imm, output bit pred,
                             output logic [31:0] rb, output logic [31:0] nxt);
    logic [31:0] tgt;
    tgt = m_pc + 32'(imm);
    case (kind)
      K_JAL: begin
        pred = 1'b1; nxt = tgt; rb = m_pc + 32'd4;
      end
      K_BR: begin
        pred = m_predict(m_pc);
        nxt  = pred ? tgt : m_pc + 32'd4;
        rb   = pred ? m_pc + 32'd4 : tgt;
      end
      default: begin
        pred = 1'b0; nxt = m_pc + 32'd4; rb = m_pc + 32'd4;
      end
    endcase
  endtask

  // driver tasks
  task automatic wait_req();
    int n;
    n = 0;
    while (en_signal_to_mem !== 1'b1 && n < 50) begin
      @(posedge clk_in); #1;
      n++;
    end
    checks++;
    if (en_signal_to_mem !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: en_signal_to_mem=%b required 1 within 50 cycles", en_signal_to_mem);
    end
  endtask

  task automatic check_req_pc(input string name);
    checks++;
    if (pc_to_mem !== m_pc) begin
      errors++;
      $display("FAIL %s: pc_to_mem=%h required %h", name, pc_to_mem, m_pc);
    end
  endtask

  task automatic respond(input int kind, input int imm, input bit same_upd);
    logic [31:0] inst, exp_rb, exp_next, exp_pc;
    bit          exp_pred, upd_taken;
    inst = enc(kind, imm);
    model_fetch(kind, imm, exp_pred, exp_rb, exp_next);
    exp_q.push_back(m_pc);
    upd_taken = 1'($urandom_range(0, 1));
    ok_flag_from_mem = 1'b1;
    inst_from_mem    = inst;
    if (same_upd) begin
      bht_update_en    = 1'b1;
      bht_update_pc    = m_pc;
      bht_update_taken = upd_taken;
    end
    @(posedge clk_in); #1;
    ok_flag_from_mem = 1'b0;
    bht_update_en    = 1'b0;
    if (same_upd) m_update(m_pc, upd_taken);
    exp_pc = exp_q.pop_front();
    checks++;
    if (ok_flag_to_dispatcher !== 1'b1 || pc_to_dispatcher !== exp_pc) begin
      errors++;
      $display("FAIL pulse_pc: ok=%b pc=%h required ok=1 pc=%h", ok_flag_to_dispatcher, pc_to_dispatcher, exp_pc);
    end
    checks++;
    if (inst_to_dispatcher !== inst) begin
      errors++;
      $display("FAIL pulse_inst: inst=%h required %h", inst_to_dispatcher, inst);
    end
    checks++;
    if (predicted_jump_to_dispatcher !== exp_pred || rollback_pc_to_dispatcher !== exp_rb) begin
      errors++;
      $display("FAIL pulse_pred: pred=%b rb_pc=%h required pred=%b rb_pc=%h",
               predicted_jump_to_dispatcher, rollback_pc_to_dispatcher, exp_pred, exp_rb);
    end
    checks++;
    if (en_signal_to_mem !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: en_signal_to_mem=%b required 0", en_signal_to_mem);
    end
    m_pc = exp_next;
  endtask

  // After a pulse: either check its width, or hold a full flag for some
  // cycles (optionally with a rollback while IDLE) and check the release.
  task automatic tail(input int stall, input int sel, input bit do_rb, input logic [31:0] target);
    int s;
    if (stall == 0) begin
      @(posedge clk_in); #1;
      checks++;
      if (ok_flag_to_dispatcher !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width: ok_flag_to_dispatcher=%b required 0", ok_flag_to_dispatcher);
      end
    end else begin
      s = (sel < 0) ? int'($urandom_range(0, 2)) : sel;
      rob_full = (s == 0);
      rs_full  = (s == 1);
      lsb_full = (s == 2);
      for (int i = 0; i < stall; i++) begin
        if (do_rb && i == 1) begin
          rollback_flag_from_rob = 1'b1;
          rollback_pc_from_rob   = target;
        end
        @(posedge clk_in); #1;
        if (rollback_flag_from_rob) begin
          rollback_flag_from_rob = 1'b0;
          m_pc = target;
        end
        checks++;
        if (en_signal_to_mem !== 1'b0 || ok_flag_to_dispatcher !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: en=%b ok=%b required en=0 ok=0", en_signal_to_mem, ok_flag_to_dispatcher);
        end
      end
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      @(posedge clk_in); #1;
      checks++;
      if (en_signal_to_mem !== 1'b1 || pc_to_mem !== m_pc) begin
        errors++;
        $display("FAIL stall_release: en=%b pc_to_mem=%h required en=1 pc_to_mem=%h",
                 en_signal_to_mem, pc_to_mem, m_pc);
      end
    end
  endtask

  task automatic fetch_one(input int kind, input int imm, input int lat, input bit rnd_upd, input int stall);
    bit          upd, t;
    logic [31:0] p;
    wait_req();
    check_req_pc("req_pc");
    for (int i = 0; i < lat; i++) begin
      upd = rnd_upd && ($urandom_range(0, 2) == 0);
      t   = 1'($urandom_range(0, 1));
      p   = ($urandom_range(0, 1) == 1) ? m_pc : (32'($urandom_range(0, 255)) << 2);
      if (upd) begin
        bht_update_en = 1'b1; bht_update_pc = p; bht_update_taken = t;
      end
      @(posedge clk_in); #1;
      bht_update_en = 1'b0;
      if (upd) m_update(p, t);
      checks++;
      if (en_signal_to_mem !== 1'b1 || ok_flag_to_dispatcher !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold: en=%b ok=%b required en=1 ok=0", en_signal_to_mem, ok_flag_to_dispatcher);
      end
    end
    respond(kind, imm, rnd_upd && ($urandom_range(0, 1) == 1));
    tail(stall, -1, 1'b0, 32'h0);
  endtask

  task automatic bht_upd(input logic [31:0] pc, input bit taken);
    bht_update_en = 1'b1; bht_update_pc = pc; bht_update_taken = taken;
    @(posedge clk_in); #1;
    bht_update_en = 1'b0;
    m_update(pc, taken);
  endtask

  task automatic rollback_busy(input logic [31:0] target, input bit simultaneous);
    wait_req();
    check_req_pc("rb_req_pc");
    rollback_flag_from_rob = 1'b1;
    rollback_pc_from_rob   = target;
    if (simultaneous) begin
      ok_flag_from_mem = 1'b1;
      inst_from_mem    = enc(K_JAL, 64);
    end
    @(posedge clk_in); #1;
    rollback_flag_from_rob = 1'b0;
    ok_flag_from_mem       = 1'b0;
    m_pc = target;
    checks++;
    if (ok_flag_to_dispatcher !== 1'b0 || en_signal_to_mem !== !simultaneous) begin
      errors++;
      $display("FAIL rb_state: ok=%b en=%b required ok=0 en=%b", ok_flag_to_dispatcher, en_signal_to_mem, !simultaneous);
    end
    if (!simultaneous) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_in); #1;
        checks++;
        if (en_signal_to_mem !== 1'b1) begin
          errors++;
          $display("FAIL drain_hold: en=%b required 1", en_signal_to_mem);
        end
      end
      ok_flag_from_mem = 1'b1;
      inst_from_mem    = enc(K_JAL, 64);
      @(posedge clk_in); #1;
      ok_flag_from_mem = 1'b0;
      checks++;
      if (ok_flag_to_dispatcher !== 1'b0 || en_signal_to_mem !== 1'b0) begin
        errors++;
        $display("FAIL drain_discard: ok=%b en=%b required ok=0 en=0", ok_flag_to_dispatcher, en_signal_to_mem);
      end
    end
    wait_req();
    check_req_pc("rb_redirect");
  endtask

  // scenarios
  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1;
    ok_flag_from_mem = 1'b0; inst_from_mem = 32'h0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
    rollback_flag_from_rob = 1'b0; rollback_pc_from_rob = 32'h0;
    bht_update_en = 1'b0; bht_update_pc = 32'h0; bht_update_taken = 1'b0;
    m_reset();
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (en_signal_to_mem !== 1'b0 || pc_to_mem !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: en=%b pc_to_mem=%h required 0 0", en_signal_to_mem, pc_to_mem);
    end
    checks++;
    if (ok_flag_to_dispatcher !== 1'b0 || predicted_jump_to_dispatcher !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: ok=%b pred=%b required 0 0", ok_flag_to_dispatcher, predicted_jump_to_dispatcher);
    end
    checks++;
    if (pc_to_dispatcher !== 32'h0 || inst_to_dispatcher !== 32'h0 || rollback_pc_to_dispatcher !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: pc=%h inst=%h rb=%h required all 0",
               pc_to_dispatcher, inst_to_dispatcher, rollback_pc_to_dispatcher);
    end
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    checks++;
    if (en_signal_to_mem !== 1'b1 || pc_to_mem !== RST_PC) begin
      errors++;
      $display("FAIL first_req: en=%b pc_to_mem=%h required 1 %h", en_signal_to_mem, pc_to_mem, RST_PC);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++)
      fetch_one(K_ADDI, int'($urandom_range(0, 2047)), int'($urandom_range(0, 3)), 1'b0, 0);
  endtask

  task automatic test_jal();
    fetch_one(K_ADDI, 5, 1, 1'b0, 0);       // PC 0xC
    fetch_one(K_JAL, 32'h20, 2, 1'b0, 0);   // PC 0x10 -> 0x30
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) fetch_one(K_ADDI, i, 0, 1'b0, 0);  // 0x30..0x3C
    fetch_one(K_BR, -8, 1, 1'b0, 0);        // 0x40, counter at reset value
    wait_req();
    bht_upd(32'h40, 1'b1);
    bht_upd(32'h40, 1'b1);
    rollback_busy(32'h40, 1'b0);
    fetch_one(K_BR, -8, 0, 1'b0, 0);        // prediction now from updated counter
    fetch_one(K_ADDI, 1, 0, 1'b0, 0);
  endtask

  task automatic test_stall();
    wait_req();
    check_req_pc("stall_req_pc");
    respond(K_ADDI, 3, 1'b0);
    tail(3, 0, 1'b0, 32'h0);                // rob_full
    wait_req();
    respond(K_ADDI, 4, 1'b0);
    tail(2, 1, 1'b0, 32'h0);                // rs_full
    wait_req();
    respond(K_LUI, 32'h12345000, 1'b0);
    tail(4, 2, 1'b1, 32'h80);               // lsb_full with rollback in IDLE
  endtask

  task automatic test_rollback();
    rollback_busy(32'h100, 1'b0);
    fetch_one(K_ADDI, 7, 1, 1'b0, 0);       // 0x100, request for 0x104 in flight
    rollback_busy(32'h100, 1'b1);
  endtask

  task automatic test_rdy_pause();
    wait_req();
    check_req_pc("rdy_req_pc");
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    ok_flag_from_mem = 1'b1;
    inst_from_mem    = enc(K_JAL, 64);
    bht_update_en = 1'b1; bht_update_pc = m_pc; bht_update_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      ok_flag_from_mem = 1'b0;
      checks++;
      if (en_signal_to_mem !== 1'b1 || pc_to_mem !== m_pc || ok_flag_to_dispatcher !== 1'b0) begin
        errors++;
        $display("FAIL rdy_hold: en=%b pc_to_mem=%h ok=%b required 1 %h 0",
                 en_signal_to_mem, pc_to_mem, ok_flag_to_dispatcher, m_pc);
      end
    end
    bht_update_en = 1'b0;
    rdy_in = 1'b1;
    respond(K_BR, -16, 1'b0);
    tail(0, -1, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    rollback_busy(32'hFFFF_FFF8, 1'b0);
    fetch_one(K_JAL, 16, 1, 1'b0, 0);       // wraps to 0x8
    rollback_busy(32'hFFFF_FFFC, 1'b0);
    fetch_one(K_BR, 8, 0, 1'b0, 0);
    fetch_one(K_ADDI, 2, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int kind, imm;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        K_JAL:   imm = (int'($urandom_range(0, 511)) - 256) * 4;
        K_BR:    imm = (int'($urandom_range(0, 255)) - 128) * 4;
        default: imm = int'($urandom());
      endcase
      fetch_one(kind, imm, int'($urandom_range(0, 4)), 1'b1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_stall();
    test_rollback();
    test_rdy_pause();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
